// File: rtl/tx_port_arbiter_pkg.sv
// Shared definitions for the MAC transmit-port arbiter: FSM encoding, beat widths
// and a constant-evaluable clog2.
package tx_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after last_idx, wrapping
// modulo N. Shared with any other arbiter that needs the same fairness rule.
module tx_port_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_idx_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_idx_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(last_idx_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tx_port_arbiter.sv
// Round-robin owner of the single MAC transmit port: grants one source for a
// whole frame, muxes its stream, enforces an inter-frame gap and a stall watchdog.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate pending requests
// ST_GRANT | grant registered; one cycle for the source to prime its buffer
// ST_XFER  | granted stream routed to the MAC until accepted tlast or watchdog
// ST_GAP   | forced idle between frames; requests are held until IDLE
module tx_port_arbiter
  import tx_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int IFG_CYCLES = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic [NUM_REQ-1:0]        vld_i,
  input  logic [DATA_W*NUM_REQ-1:0] data_i,
  input  logic [KEEP_W*NUM_REQ-1:0] tkeep_i,
  input  logic [NUM_REQ-1:0]        tlast_i,
  output logic [NUM_REQ-1:0]        rdy_o,
  output logic [DATA_W-1:0]         mac_tx_data_o,
  output logic [KEEP_W-1:0]         mac_tx_tkeep_o,
  output logic                      mac_tx_valid_o,
  output logic                      mac_tx_last_o,
  input  logic                      mac_tx_rdy_i,
  output logic                      timeout_o,
  output logic [15:0]               frame_cnt_o,
  output logic                      busy_o
);

  localparam int WD_W = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LOAD  = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      GAP_LOAD = (IFG_CYCLES == 0) ? 4'd0 : 4'(IFG_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [3:0]         gap_q, gap_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               in_xfer;
  logic               sel_vld;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               accept;
  logic               wd_hit;

  tx_port_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req_i      (req_i),
    .last_idx_i (last_idx_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  always_comb begin
    in_xfer  = (state_q == ST_XFER);
    sel_vld  = vld_i[gidx_q];
    sel_last = tlast_i[gidx_q];
    sel_data = data_i[int'(gidx_q)*DATA_W +: DATA_W];
    sel_keep = tkeep_i[int'(gidx_q)*KEEP_W +: KEEP_W];
    accept   = in_xfer & sel_vld & mac_tx_rdy_i;
    // An accepted beat on the terminal cycle still counts as progress.
    wd_hit   = in_xfer & ~accept & (wd_q == '0);

    mac_tx_valid_o = in_xfer & sel_vld;
    mac_tx_last_o  = in_xfer & sel_last;
    mac_tx_data_o  = in_xfer ? sel_data : '0;
    mac_tx_tkeep_o = in_xfer ? sel_keep : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rdy_o[k] = in_xfer & mac_tx_rdy_i & (gidx_q == IDX_W'(k));
    end

    timeout_o   = wd_hit;
    gnt_o       = gnt_q;
    frame_cnt_o = frame_cnt_q;
    busy_o      = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    last_idx_d  = last_idx_q;
    gnt_d       = gnt_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d    = WD_LOAD;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (accept) begin
          wd_d = WD_LOAD;
          if (sel_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            last_idx_d  = gidx_q;
            gnt_d       = '0;
            gap_d       = GAP_LOAD;
            state_d     = ST_GAP;
          end
        end else if (wd_hit) begin
          last_idx_d = gidx_q;
          gnt_d      = '0;
          gap_d      = GAP_LOAD;
          state_d    = ST_GAP;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      gidx_q      <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      last_idx_q  <= last_idx_d;
      gnt_q       <= gnt_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Directed-plus-random bench for tx_port_arbiter against a round-robin frame model.
module tb_tx_port_arbiter;

  localparam int N   = 4;
  localparam int IFG = 3;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, vld = '0, tlast = '0;
  logic [32*N-1:0] data = '0;
  logic [4*N-1:0]  keep = '0;
  logic            mrdy = 1'b0;
  logic [N-1:0]    gnt, rdy;
  logic [31:0]     mdata;
  logic [3:0]      mkeep;
  logic            mvalid, mlast, tmo, busy;
  logic [15:0]     fcnt;

  int vectors = 0;
  int errors  = 0;
  int last_exp = N - 1;
  int fcnt_exp = 0;

  always #5 clk = ~clk;

  tx_port_arbiter #(
    .NUM_REQ(N), .IDX_W(2), .IFG_CYCLES(IFG), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(req), .gnt_o(gnt), .vld_i(vld),
    .data_i(data), .tkeep_i(keep), .tlast_i(tlast), .rdy_o(rdy),
    .mac_tx_data_o(mdata), .mac_tx_tkeep_o(mkeep), .mac_tx_valid_o(mvalid),
    .mac_tx_last_o(mlast), .mac_tx_rdy_i(mrdy), .timeout_o(tmo),
    .frame_cnt_o(fcnt), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester after the previous owner, wrapping.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fcnt"}, fcnt, 0);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_valid"}, mvalid, 0);
  endtask

  task automatic do_frame(input logic [N-1:0] req_vec, input logic [N-1:0] next_req,
                          input int nbeats, input int mode, input int abort_beat,
                          output int lat, output int obs_src);
    int exp_src, beat, xc, gapc;
    logic [31:0] bd;
    logic [3:0] bk;
    logic exp_to;
    logic [N-1:0] oh;
    exp_src = rr_model(req_vec, last_exp);
    oh = (exp_src >= 0) ? N'(1) << exp_src : '0;
    obs_src = -1;
    @(posedge clk); #1;
    req = req_vec; vld = '0; tlast = '0; mrdy = 1'($urandom_range(0, 1));
    lat = 0;
    @(negedge clk);
    while (gnt == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < N; k++) if (gnt[k]) obs_src = k;
    chk("grant_onehot", gnt, oh);
    chk("grant_rdy", rdy, 0);
    chk("grant_valid", mvalid, 0);
    chk("grant_busy", busy, 1);
    if (gnt == '0) return;

    beat = 0; xc = 0;
    bd = $urandom; bk = (nbeats == 1) ? 4'h3 : 4'hF;
    while (xc < 200) begin
      @(posedge clk); #1;
      xc++;
      for (int k = 0; k < N; k++) begin
        if (k != exp_src) begin
          vld[k] = 1'($urandom_range(0, 1));
          tlast[k] = 1'($urandom_range(0, 1));
          data[32*k +: 32] = $urandom;
          keep[4*k +: 4] = 4'($urandom_range(0, 15));
        end
      end
      case (mode)
        0: mrdy = 1'b1;
        1: mrdy = (xc % 2 == 1);
        default: mrdy = ($urandom_range(0, 3) != 0);
      endcase
      if (mode >= 2 && xc == 1) req[exp_src] = 1'b0;
      vld[exp_src] = (nbeats > 0) && (mode < 2 || $urandom_range(0, 3) != 0);
      tlast[exp_src] = (nbeats > 0) && (beat == nbeats - 1);
      data[32*exp_src +: 32] = bd;
      keep[4*exp_src +: 4] = bk;
      exp_to = (nbeats == 0) && (xc == TO);
      @(negedge clk);
      chk("xfer_gnt", gnt, oh);
      chk("xfer_rdy", rdy, mrdy ? oh : '0);
      chk("xfer_valid", mvalid, vld[exp_src]);
      chk("xfer_last", mlast, tlast[exp_src]);
      chk("xfer_timeout", tmo, exp_to);
      chk("xfer_busy", busy, 1);
      if (vld[exp_src]) begin
        chk("xfer_data", mdata, bd);
        chk("xfer_keep", mkeep, bk);
      end
      if (vld[exp_src] && mrdy) begin
        beat++;
        if (abort_beat > 0 && beat == abort_beat) begin
          #2 rst_n = 1'b0;
          #1 chk_reset_outputs("async_rst");
          last_exp = N - 1; fcnt_exp = 0;
          req = '0; vld = '0; tlast = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (beat == nbeats) break;
        bd = $urandom; bk = (beat == nbeats - 1) ? 4'h3 : 4'hF;
      end
      if (exp_to) break;
    end
    chk("beats_accepted", beat, nbeats);
    if (nbeats > 0 && beat == nbeats) fcnt_exp = (fcnt_exp + 1) % 65536;
    last_exp = exp_src;

    @(posedge clk); #1;
    req = next_req;
    vld = N'($urandom_range(0, 15)); tlast = N'($urandom_range(0, 15));
    mrdy = 1'($urandom_range(0, 1));
    gapc = 0;
    @(negedge clk);
    chk("gap_fcnt", fcnt, fcnt_exp);
    chk("gap_timeout", tmo, 0);
    while (busy && gapc < 40) begin
      gapc++;
      chk("gap_gnt", gnt, 0);
      chk("gap_valid", mvalid, 0);
      chk("gap_rdy", rdy, 0);
      @(negedge clk);
    end
    chk("gap_len", gapc, IFG);
    vld = '0; tlast = '0;
  endtask

  initial begin
    int lat, src, w;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] pend, nxt;

    #12 chk_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk_reset_outputs("idle");

    // all requesting, single-beat frames
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, (i == 4) ? 4'b0000 : 4'b1111, 1, 0, 0, lat, src);
      chk("fair_order", src, order[i]);
    end
    chk("fair_fcnt", fcnt, 5);

    // 5-beat frame from source 2 out of idle
    do_frame(4'b0100, 4'b0000, 5, 0, 0, lat, src);
    chk("first_latency", lat, 1);
    chk("s2_src", src, 2);

    // 8 beats from source 1 with ready toggling
    do_frame(4'b0010, 4'b0000, 8, 1, 0, lat, src);
    chk("toggle_src", src, 1);

    // random traffic
    pend = N'($urandom_range(1, 15));
    for (int i = 0; i < 25; i++) begin
      w = rr_model(pend, last_exp);
      nxt = (pend & ~(N'(1) << w)) | N'($urandom_range(0, 15));
      if (nxt == '0) nxt = N'(1) << $urandom_range(0, N - 1);
      if (i == 24) nxt = '0;
      do_frame(pend, nxt, $urandom_range(1, 6), $urandom_range(0, 2), 0, lat, src);
      pend = nxt;
    end

    // watchdog on stalled source 3, then source 0 next
    do_frame(4'b0100, 4'b1001, 2, 0, 0, lat, src);
    w = fcnt_exp;
    do_frame(4'b1001, 4'b0001, 0, 0, 0, lat, src);
    chk("wd_src", src, 3);
    chk("wd_fcnt_held", fcnt, w);
    do_frame(4'b0001, 4'b0000, 2, 0, 0, lat, src);
    chk("after_wd_src", src, 0);

    // counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    fcnt_exp = 16'hFFFF;
    chk("preload", fcnt, 16'hFFFF);
    do_frame(4'b1000, 4'b0000, 3, 2, 0, lat, src);
    chk("wrap_zero", fcnt, 0);

    // reset mid-frame, then a clean frame
    do_frame(4'b0100, 4'b0000, 6, 0, 3, lat, src);
    do_frame(4'b0001, 4'b0000, 4, 0, 0, lat, src);
    chk("post_rst_src", src, 0);
    chk("post_rst_fcnt", fcnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
